// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and constants for the memory-mapped square-root engine.
//   Provides the engine state encoding, the default operand/result addresses
//   and the datapath widths used by sqrt_mem_engine and sqrt_step.
package sqrt_pkg;
   localparam int ROOT_W = 8;
   localparam int REM_W  = 10;
   localparam logic [7:0] OPERAND_ADDR_DEF = 8'd16;
   localparam logic [7:0] RESULT_ADDR_DEF  = 8'd18;
   typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, CALC, ROUND, WR, DONE} state_e;
endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational restoring square-root digit step.
//   rem_i  - partial remainder before this step
//   root_i - partial root before this step
//   bits_i - next two operand bits, most significant pair first
//   rem_o  - partial remainder after this step
//   root_o - partial root after this step
module sqrt_step
   import sqrt_pkg::*;
(
   input  logic [REM_W-1:0]  rem_i,
   input  logic [ROOT_W-1:0] root_i,
   input  logic [1:0]        bits_i,
   output logic [REM_W-1:0]  rem_o,
   output logic [ROOT_W-1:0] root_o
);
   logic [REM_W-1:0] rem_sh;
   logic [REM_W-1:0] trial;
   logic             fits;
   // The remainder never exceeds twice the partial root, so the top two bits
   // dropped by the shift are always zero.
   assign rem_sh = {rem_i[REM_W-3:0], bits_i};
   assign trial  = {root_i, 2'b01};
   assign fits   = rem_sh >= trial;
   assign rem_o  = fits ? rem_sh - trial : rem_sh;
   assign root_o = {root_i[ROOT_W-2:0], fits};
endmodule

// File: rtl/sqrt_mem_engine.sv
// sqrt_mem_engine: start/halt responder that reads a 16-bit operand from data
// memory, computes its 8-bit integer square root and writes it back.
//   CLK         - system clock, rising edge
//   reset_n     - synchronous active-low reset
//   start       - high holds the engine; a high-to-low edge launches one operation
//   halt        - level done flag, held until start returns high
//   mem_addr    - data-memory address (holds its value between accesses)
//   mem_rd_data - combinational data-memory read data
//   mem_wr_en   - one-cycle write strobe for the result
//   mem_wr_data - result byte
//   busy        - high in every state except IDLE and DONE
// Build option: define SQRT_ROUND_EN for round-to-nearest (saturating at 255);
// otherwise the floor square root is written.
module sqrt_mem_engine
   import sqrt_pkg::*;
#(
   parameter int          AW           = 8,
   parameter logic [AW-1:0] OPERAND_ADDR = AW'(OPERAND_ADDR_DEF),
   parameter logic [AW-1:0] RESULT_ADDR  = AW'(RESULT_ADDR_DEF)
) (
   input  logic          CLK,
   input  logic          reset_n,
   input  logic          start,
   output logic          halt,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wr_data,
   output logic          busy
);
   state_e            state_q, state_d;
   logic              start_q;
   logic [15:0]       operand_q, operand_d;
   logic [REM_W-1:0]  rem_q, rem_d, step_rem;
   logic [ROOT_W-1:0] root_q, root_d, step_root, result;
   logic [2:0]        iter_q, iter_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              launch, abort, active;

   assign active = state_q inside {RD_HI, RD_LO, CALC, ROUND, WR};
   assign launch = start_q & ~start & (state_q == IDLE || state_q == DONE);
   assign abort  = active & start;

   sqrt_step u_step (
      .rem_i  (rem_q),
      .root_i (root_q),
      .bits_i (operand_q[{iter_q, 1'b0} +: 2]),
      .rem_o  (step_rem),
      .root_o (step_root)
   );

   // After CALC, rem_q = x - r*r and root_q = floor(sqrt(x)).
`ifdef SQRT_ROUND_EN
   assign result = (rem_q > {2'b00, root_q} && root_q != 8'hFF) ? root_q + 8'd1 : root_q;
`else
   assign result = root_q;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = launch ? RD_HI : IDLE;
         RD_HI:   state_d = RD_LO;
         RD_LO:   state_d = CALC;
         CALC:    state_d = (iter_q == 3'd0) ? ROUND : CALC;
         ROUND:   state_d = WR;
         WR:      state_d = DONE;
         DONE:    state_d = launch ? RD_HI : (start ? IDLE : DONE);
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_comb begin
      operand_d = state_q == RD_HI ? {mem_rd_data, operand_q[7:0]}
                : state_q == RD_LO ? {operand_q[15:8], mem_rd_data} : operand_q;
      rem_d     = state_q == RD_LO ? '0 : state_q == CALC ? step_rem : rem_q;
      root_d    = state_q == RD_LO ? '0 : state_q == CALC ? step_root : root_q;
      iter_d    = state_q == RD_LO ? 3'd7 : state_q == CALC ? iter_q - 3'd1 : iter_q;
      // Address is registered, so it is set up on entry to each access state.
      addr_d    = state_d == RD_HI ? OPERAND_ADDR
                : state_d == RD_LO ? OPERAND_ADDR + AW'(1)
                : state_d == WR    ? RESULT_ADDR : addr_q;
      wr_data_d = state_d == WR ? result : wr_data_q;
   end

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         start_q   <= 1'b0;
         operand_q <= '0;
         rem_q     <= '0;
         root_q    <= '0;
         iter_q    <= '0;
         addr_q    <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= start;
         operand_q <= operand_d;
         rem_q     <= rem_d;
         root_q    <= root_d;
         iter_q    <= iter_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign halt        = state_q == DONE;
   assign busy        = active;
   assign mem_addr    = addr_q;
   assign mem_wr_data = wr_data_q;
   // A start rising during WR aborts, so the strobe is suppressed in that cycle.
   assign mem_wr_en   = (state_q == WR) & ~start;
endmodule

// File: tb/tb_sqrt_mem_engine.sv
// tb_sqrt_mem_engine: self-checking bench for sqrt_mem_engine with a memory model and result scoreboard.
module tb_sqrt_mem_engine;
   logic       CLK = 1'b0;
   logic       reset_n;
   logic       start;
   logic       halt;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
   logic       busy;
   logic [7:0] mem [0:255];
   logic [7:0] sb [$];
   int         tests = 0;
   int         fails = 0;
   int         wr_cnt = 0;

   sqrt_mem_engine dut (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .start       (start),
      .halt        (halt),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .busy        (busy)
   );

   always #5 CLK = ~CLK;

   assign mem_rd_data = mem[mem_addr];

   always @(posedge CLK) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

   always @(negedge CLK) begin
      if (mem_wr_en) begin
         logic [7:0] exp;
         wr_cnt++;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_unexpected_write observed=%h expected=none", mem_wr_data);
         end else begin
            exp = sb.pop_front();
            assert (mem_wr_data === exp && mem_addr === 8'd18) else begin
               fails++;
               $error("FAIL sb_result observed=%h@%0d expected=%h@18", mem_wr_data, mem_addr, exp);
            end
         end
      end
   end

   function automatic logic [7:0] model(input logic [15:0] x);
      int r = 0;
      while ((r + 1) * (r + 1) <= int'(x)) r++;
`ifdef SQRT_ROUND_EN
      if (int'(x) - r * r > r && r != 255) r++;
`endif
      return r[7:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [15:0] x);
      mem[16] = x[15:8];
      mem[17] = x[7:0];
      mem[18] = 8'hAA;
      @(negedge CLK) start = 1'b1;
      @(negedge CLK) start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [15:0] x);
      int lat = 0;
      logic [7:0] exp;
      exp = model(x);
      sb.push_back(exp);
      launch(x);
      while (lat < 40) begin
         @(posedge CLK);
         lat++;
         #1;
         if (mem_wr_en) break;
      end
      check({tag, "_latency"}, lat, 12);
      @(posedge CLK);
      #1;
      check({tag, "_halt"}, halt, 1);
      check({tag, "_mem"}, mem[18], exp);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset_n = 1'b0;
      start   = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_halt", halt, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wr_data", mem_wr_data, 0);
      @(negedge CLK) reset_n = 1'b1;

      run_op("x211", 16'd211);
      run_op("xffff", 16'hFFFF);
      run_op("x0", 16'd0);
      run_op("x240", 16'd240);
      run_op("x241", 16'd241);

      // Abort during the third CALC cycle.
      begin
         int w0;
         w0 = wr_cnt;
         launch(16'd5000);
         repeat (5) @(posedge CLK);
         #1;
         check("abort_busy_before", busy, 1);
         @(negedge CLK) start = 1'b1;
         repeat (20) @(posedge CLK);
         #1;
         check("abort_no_write", wr_cnt, w0);
         check("abort_halt", halt, 0);
         check("abort_busy", busy, 0);
         check("abort_mem", mem[18], 8'hAA);
      end
      run_op("after_abort", 16'h1234);

      // Reset mid-CALC with start held low afterwards.
      begin
         int w0;
         w0 = wr_cnt;
         launch(16'd777);
         repeat (6) @(posedge CLK);
         @(negedge CLK) reset_n = 1'b0;
         repeat (2) @(posedge CLK);
         @(negedge CLK) reset_n = 1'b1;
         repeat (20) @(posedge CLK);
         #1;
         check("rstmid_no_write", wr_cnt, w0);
         check("rstmid_halt", halt, 0);
         check("rstmid_busy", busy, 0);
      end
      run_op("after_reset", 16'd1000);
      run_op("x65024", 16'd65024);

      repeat (3) @(posedge CLK);
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sqrt_mem_engine.md
Name: sqrt_mem_engine

Overview:
- Hardware responder for the start/halt program handshake.
- After the controller releases `start`, it reads a 16-bit operand from data memory, bytes at OPERAND_ADDR (MSB) and OPERAND_ADDR+1 (LSB).
- Computes the 8-bit integer square root, rounded to nearest and saturated at 255, writes it to RESULT_ADDR, then raises `halt`.
- Sits beside the data memory as a second master, replacing the software sqrt program.

Parameters:
- AW, 8, data-memory address width.
- OPERAND_ADDR, 16, address of operand MSB; the LSB is at OPERAND_ADDR+1.
- RESULT_ADDR, 18, address the 8-bit result is written to.

Ports:
- CLK  input  1  system clock, all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  high = hold/load phase; a high-to-low transition launches one operation.
- halt  output  1  done flag, level.
- mem_addr  output  AW  data-memory address.
- mem_rd_data  input  8  data-memory read data; combinational read, valid in the same cycle as mem_addr.
- mem_wr_en  output  1  one-cycle write strobe.
- mem_wr_data  output  8  write data.
- busy  output  1  high in every state other than IDLE and DONE.

Behaviour:
- Reset (reset_n=0 at a CLK edge) forces state=IDLE and halt=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0. It also clears the internal regs: operand, rem, root, iter counter, and start_q.
- start_q is start registered every cycle. Launch condition: start_q=1 and start=0 while in IDLE or DONE.
- IDLE: outputs idle. On launch go to RD_HI.
- RD_HI: drive mem_addr=OPERAND_ADDR; capture operand[15:8]. Next state RD_LO.
- RD_LO: drive mem_addr=OPERAND_ADDR+1; capture operand[7:0]; clear rem and root; iter=7. Next state CALC.
- CALC: one restoring digit step per cycle, 8 cycles, iter counts 7 down to 0.
  - rem = (rem<<2) | operand[2*iter+1 : 2*iter]
  - trial = (root<<2) | 1
  - If rem >= trial: rem -= trial and root = (root<<1)|1; otherwise root = root<<1.
  - rem is 10 bits wide; root is 8 bits.
  - Go to ROUND after iter=0.
- ROUND: final rem = x - r², where r = floor(sqrt(x)).
  - If rem > r and r != 255: result = r+1; otherwise result = r.
  - 255 never wraps to 0.
- WR: drive mem_addr=RESULT_ADDR, mem_wr_data=result, mem_wr_en=1 for exactly this cycle. Next state DONE.
- DONE: halt=1 and held.
  - start going to 1 returns the block to IDLE with halt=0.
  - A fresh launch from DONE goes directly to RD_HI.
- Latency: 12 cycles from the first cycle start is seen low to the write; halt rises on the next edge.
- Operand 0 takes the same path and writes 0; there is no special trap.
- start returning to 1 during RD_HI through WR aborts to IDLE. No write occurs and halt stays 0.
- Reset mid-operation: immediate IDLE, no write.
- start held low through reset does not launch; launch needs a fresh high-to-low edge.
- When no access is active, mem_addr holds its last value and mem_wr_en=0.

Optional Feature:
- Macro SQRT_ROUND_EN.
- Defined: ROUND applies round-to-nearest as described above.
- Undefined: ROUND passes r straight through (floor sqrt). The state and latency are unchanged.

Decomposition:
- Package sqrt_pkg holds:
  - state enum {IDLE, RD_HI, RD_LO, CALC, ROUND, WR, DONE};
  - default address constants 8'd16 and 8'd18;
  - ROOT_W=8, REM_W=10.
- Sub-module sqrt_step: combinational single digit step, with inputs rem, root, and a 2-bit operand slice, and outputs next rem and next root. It is instantiated once inside the CALC datapath.

Test Plan:
- mem[16]=0x00, mem[17]=0xD3 (211), start 1→0: mem[18]=0x0F (15) written at cycle 12, halt=1 next cycle. Without SQRT_ROUND_EN, mem[18]=0x0E.
- Operand 0xFFFF: mem[18]=0xFF (floor 255, rem 510 > 255 but saturates), no wrap.
- Operand 0: mem[18]=0x00, halt asserts with the same latency.
- Operands 240 and 241: results 0x0F and 0x10 respectively (rounding threshold x > r²+r).
- Raise start at CALC cycle 3: no mem_wr_en pulse, halt=0, state IDLE. A following 1→0 edge produces a correct result.
- Pull reset_n low during CALC, then release with start held 0: no launch and no write until start toggles 1→0.
